// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: FSM encoding and the
// reserved UART control words.
package debug_pkg;

  typedef enum logic [2:0] {
    RECVPROG,
    RECVMODE,
    RUNSTEP,
    RUNALL,
    SENDPC,
    SENDDM,
    SENDRB,
    SENDCLK
  } state_t;

  localparam logic [31:0] STEP_CODE = 32'h1000_1000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_controller.sv
// UART-driven debug controller: loads a program into IM, runs the CPU
// stepwise or to halt, then dumps PC, DM words, registers and cycle count.
module debug_controller
  import debug_pkg::*;
#(
  parameter int IM_ADDR_LENGTH = 32,
  parameter int IM_MEM_SIZE    = 5,
  parameter int INST_WIDTH     = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int DM_MEM_SIZE    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int RBITS          = 5,
  parameter int BANK_SIZE      = 2,
  parameter int REG_WIDTH      = 32,
  parameter int NBITS          = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NBITS-1:0]          rx_Data,
  input  logic                      rx_done,
  input  logic                      tx_done,
  input  logic                      halt_flag,
  input  logic [REG_WIDTH-1:0]      RB_Data,
  input  logic [DATA_WIDTH-1:0]     DM_Data,
  input  logic [NBITS-1:0]          current_PC,
  input  logic [NBITS-1:0]          clock_count,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [INST_WIDTH-1:0]     IM_Data,
  output logic                      IM_We,
  output logic [RBITS-1:0]          RB_Addr,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [NBITS-1:0]          tx_Data,
  output logic                      tx_start,
  output logic                      clock_enable,
  output logic                      o_rst
);

  state_t                      state_q, state_d;
  logic [IM_ADDR_LENGTH-1:0]   im_addr_q, im_addr_d;
  logic [INST_WIDTH-1:0]       im_data_q, im_data_d;
  logic                        im_we_q, im_we_d;
  logic [NBITS-1:0]            im_cnt_q, im_cnt_d;
  logic [DM_ADDR_LENGTH-1:0]   dm_addr_q, dm_addr_d;
  logic [RBITS-1:0]            rb_addr_q, rb_addr_d;
  logic [NBITS-1:0]            idx_q, idx_d;
  logic [NBITS-1:0]            tx_data_q, tx_data_d;
  logic                        tx_start_q, tx_start_d;
  logic                        busy_q, busy_d;

  logic [NBITS-1:0]            send_word;
  logic                        last_word;
  logic                        word_done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;
    im_we_d    = 1'b0;
    im_cnt_d   = im_cnt_q;
    dm_addr_d  = dm_addr_q;
    rb_addr_d  = rb_addr_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    send_word  = '0;
    last_word  = 1'b1;
    word_done  = 1'b0;

    case (state_q)
      SENDPC:  send_word = current_PC;
      SENDDM: begin
        send_word = NBITS'(DM_Data);
        last_word = (idx_q == NBITS'(DM_MEM_SIZE - 1));
      end
      SENDRB: begin
        send_word = NBITS'(RB_Data);
        last_word = (idx_q == NBITS'(BANK_SIZE - 1));
      end
      SENDCLK: send_word = clock_count;
      default: ;
    endcase

    // Shared word handshake: launch once, then hold until the transmitter acknowledges.
    if (state_q inside {SENDPC, SENDDM, SENDRB, SENDCLK}) begin
      if (!busy_q) begin
        tx_data_d  = send_word;
        tx_start_d = 1'b1;
        busy_d     = 1'b1;
      end else if (tx_done) begin
        busy_d    = 1'b0;
        word_done = 1'b1;
      end
    end

    case (state_q)
      RECVPROG: begin
        if (im_we_q) begin
          im_addr_d = im_addr_q + IM_ADDR_LENGTH'(4);
          im_cnt_d  = im_cnt_q + NBITS'(1);
          if (im_data_q == INST_WIDTH'(HALT_WORD) ||
              im_cnt_q == NBITS'(IM_MEM_SIZE - 1)) begin
            state_d = RECVMODE;
          end
        end
        if (rx_done && state_d == RECVPROG) begin
          im_data_d = INST_WIDTH'(rx_Data);
          im_we_d   = 1'b1;
        end
      end
      RECVMODE: begin
        if (rx_done) state_d = (rx_Data == NBITS'(STEP_CODE)) ? RUNSTEP : RUNALL;
      end
      RUNSTEP: state_d = SENDPC;
      RUNALL:  if (halt_flag) state_d = SENDPC;
      SENDPC: begin
        if (word_done) begin
          idx_d   = '0;
          state_d = SENDDM;
        end
      end
      SENDDM: begin
        if (word_done) begin
          if (last_word) begin
            idx_d     = '0;
            dm_addr_d = '0;
            state_d   = SENDRB;
          end else begin
            idx_d     = idx_q + NBITS'(1);
            dm_addr_d = dm_addr_q + DM_ADDR_LENGTH'(4);
          end
        end
      end
      SENDRB: begin
        if (word_done) begin
          if (last_word) begin
            idx_d     = '0;
            rb_addr_d = '0;
            state_d   = SENDCLK;
          end else begin
            idx_d     = idx_q + NBITS'(1);
            rb_addr_d = rb_addr_q + RBITS'(1);
          end
        end
      end
      SENDCLK: begin
        if (word_done) begin
          if (halt_flag) begin
            im_addr_d = '0;
            im_cnt_d  = '0;
            state_d   = RECVPROG;
          end else begin
            state_d = RECVMODE;
          end
        end
      end
      default: state_d = RECVPROG;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RECVPROG;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      im_we_q    <= 1'b0;
      im_cnt_q   <= '0;
      dm_addr_q  <= '0;
      rb_addr_q  <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      im_we_q    <= im_we_d;
      im_cnt_q   <= im_cnt_d;
      dm_addr_q  <= dm_addr_d;
      rb_addr_q  <= rb_addr_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  // Enable drops in the same cycle halt_flag rises, so no extra CPU cycle slips through.
  assign clock_enable = (state_q == RUNSTEP) || (state_q == RUNALL && !halt_flag);
  assign o_rst        = (state_q == RECVPROG);
  assign IM_Addr      = im_addr_q;
  assign IM_Data      = im_data_q;
  assign IM_We        = im_we_q;
  assign DM_Addr      = dm_addr_q;
  assign RB_Addr      = rb_addr_q;
  assign tx_Data      = tx_data_q;
  assign tx_start     = tx_start_q;

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: stimulus pushes expected IM writes
// and tx words; independent monitors pop and compare as the DUT emits them.
module tb_debug_controller;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rx_Data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt_flag = 1'b0;
  logic [31:0] RB_Data;
  logic [31:0] DM_Data;
  logic [31:0] current_PC = '0;
  logic [31:0] clock_count = '0;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic        IM_We;
  logic [4:0]  RB_Addr;
  logic [31:0] DM_Addr;
  logic [31:0] tx_Data;
  logic        tx_start;
  logic        clock_enable;
  logic        o_rst;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } im_t;

  im_t         im_exp[$];
  logic [31:0] tx_exp[$];
  int          checks = 0;
  int          errors = 0;
  int          tx_delay = 1;
  bit          tx_busy = 1'b0;
  int          cpu_cycles = 0;
  int          halt_after = 0;
  logic [31:0] dm0 = '0;
  logic [31:0] dm1 = '0;

  always #5 clk = ~clk;

  debug_controller dut (
    .clk          (clk),
    .reset        (reset),
    .rx_Data      (rx_Data),
    .rx_done      (rx_done),
    .tx_done      (tx_done),
    .halt_flag    (halt_flag),
    .RB_Data      (RB_Data),
    .DM_Data      (DM_Data),
    .current_PC   (current_PC),
    .clock_count  (clock_count),
    .IM_Addr      (IM_Addr),
    .IM_Data      (IM_Data),
    .IM_We        (IM_We),
    .RB_Addr      (RB_Addr),
    .DM_Addr      (DM_Addr),
    .tx_Data      (tx_Data),
    .tx_start     (tx_start),
    .clock_enable (clock_enable),
    .o_rst        (o_rst)
  );

  // Memory models: two-word DM, register file returning A0 + index.
  assign DM_Data = (DM_Addr == 32'd0) ? dm0 : (DM_Addr == 32'd4) ? dm1 : 32'hDEAD_BEEF;
  assign RB_Data = 32'h0000_00A0 + {27'd0, RB_Addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [31:0] v);
    @(negedge clk);
    rx_Data = v;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while ((tx_exp.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < budget), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // CPU model: counts enabled cycles and raises halt after halt_after of them.
  initial forever begin
    logic en;
    @(negedge clk);
    en = clock_enable;
    @(posedge clk);
    #1;
    if (en) begin
      cpu_cycles++;
      if (halt_after > 0 && cpu_cycles == halt_after) halt_flag = 1'b1;
    end
  end

  // IM write monitor.
  initial forever begin
    @(negedge clk);
    if (reset && IM_We) begin
      if (im_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL im_unexpected: got addr %0h data %0h required no write", IM_Addr, IM_Data);
      end else begin
        im_t e;
        e = im_exp.pop_front();
        check("im_addr", IM_Addr, e.addr);
        check("im_data", IM_Data, e.data);
      end
    end
  end

  // Transmit monitor: compares each word, holds tx_done low for tx_delay cycles
  // while checking the word is stable and not re-requested, then acknowledges.
  initial forever begin
    @(negedge clk);
    if (reset && tx_start) begin
      logic [31:0] held;
      bit hold_ok;
      bit aborted;
      tx_busy = 1'b1;
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %0h required no word", tx_Data);
      end else begin
        check("tx_word", tx_Data, tx_exp.pop_front());
      end
      held    = tx_Data;
      hold_ok = 1'b1;
      aborted = 1'b0;
      for (int i = 0; i < tx_delay; i++) begin
        @(negedge clk);
        if (!reset) begin
          aborted = 1'b1;
          break;
        end
        if (tx_start || tx_Data !== held) hold_ok = 1'b0;
      end
      if (!aborted) begin
        check("tx_hold", 64'(hold_ok), 64'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
      tx_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_o_rst", o_rst, 1'b1);
    check("rst_clock_enable", clock_enable, 1'b0);
    check("rst_im_we", IM_We, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_im_addr", IM_Addr, 32'd0);
    check("rst_tx_data", tx_Data, 32'd0);
    reset = 1'b1;

    // Program load terminated by the halt word.
    im_exp.push_back('{32'd0, 32'h0000_00FF});
    im_exp.push_back('{32'd4, 32'h0000_000F});
    im_exp.push_back('{32'd8, 32'hFFFF_FFFF});
    send_rx(32'h0000_00FF);
    send_rx(32'h0000_000F);
    send_rx(32'hFFFF_FFFF);
    check("load_im_pending", im_exp.size(), 0);
    check("load_state", dut.state_q, RECVMODE);
    check("load_o_rst", o_rst, 1'b0);

    // Single step and dump.
    dm0 = 32'h7F; dm1 = 32'h7F;
    current_PC = 32'h02; clock_count = 32'h03;
    cpu_cycles = 0;
    tx_delay = 1;
    tx_exp.push_back(32'h02);
    tx_exp.push_back(32'h7F);
    tx_exp.push_back(32'h7F);
    tx_exp.push_back(32'hA0);
    tx_exp.push_back(32'hA1);
    tx_exp.push_back(32'h03);
    send_rx(STEP_CODE);
    wait_drained(200);
    check("step_enable_cycles", cpu_cycles, 1);
    check("step_state", dut.state_q, RECVMODE);

    // A stray tx_done with nothing outstanding must not start a transfer.
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_tx_done_state", dut.state_q, RECVMODE);

    // Run to halt with a slow transmitter.
    dm0 = 32'h11; dm1 = 32'h22;
    current_PC = 32'h40; clock_count = 32'h55;
    cpu_cycles = 0;
    halt_after = 4;
    tx_delay = 3;
    tx_exp.push_back(32'h40);
    tx_exp.push_back(32'h11);
    tx_exp.push_back(32'h22);
    tx_exp.push_back(32'hA0);
    tx_exp.push_back(32'hA1);
    tx_exp.push_back(32'h55);
    send_rx(32'h4500_3000);
    wait_drained(400);
    check("runall_enable_cycles", cpu_cycles, 4);
    check("runall_state", dut.state_q, RECVPROG);
    check("runall_o_rst", o_rst, 1'b1);
    check("runall_im_addr", IM_Addr, 32'd0);
    halt_flag = 1'b0;
    halt_after = 0;

    // Overflow: five ordinary words fill the IM and end the load.
    for (int i = 0; i < 5; i++) im_exp.push_back('{32'(4 * i), 32'(i + 1)});
    for (int i = 0; i < 4; i++) send_rx(32'(i + 1));
    check("ovf_still_loading", dut.state_q, RECVPROG);
    send_rx(32'd5);
    check("ovf_state", dut.state_q, RECVMODE);
    check("ovf_im_pending", im_exp.size(), 0);

    // Reset while the second DM word is outstanding.
    dm0 = 32'h33; dm1 = 32'h44;
    current_PC = 32'h08;
    tx_delay = 6;
    tx_exp.push_back(32'h08);
    tx_exp.push_back(32'h33);
    tx_exp.push_back(32'h44);
    @(negedge clk);
    rx_Data = STEP_CODE;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    begin
      int n = 0;
      while (tx_exp.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("mid_dm_reached", 64'(n < 200), 64'd1);
    end
    @(negedge clk);
    check("mid_dm_addr_before", DM_Addr, 32'd4);
    reset = 1'b0;
    #1;
    check("mid_rst_state", dut.state_q, RECVPROG);
    check("mid_rst_tx_start", tx_start, 1'b0);
    check("mid_rst_tx_data", tx_Data, 32'd0);
    check("mid_rst_dm_addr", DM_Addr, 32'd0);
    check("mid_rst_rb_addr", RB_Addr, 5'd0);
    check("mid_rst_im_data", IM_Data, 32'd0);
    check("mid_rst_im_addr", IM_Addr, 32'd0);
    check("mid_rst_clock_enable", clock_enable, 1'b0);
    check("mid_rst_o_rst", o_rst, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_state", dut.state_q, RECVPROG);
    check("post_rst_tx_start", tx_start, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset.
REQ-002 Parameters SHALL be, one per line:
- IM_ADDR_LENGTH, 32: IM address width.
- IM_MEM_SIZE, 5: maximum number of instruction words loadable.
- INST_WIDTH, 32: instruction width.
- DM_ADDR_LENGTH, 32: DM address width.
- DM_MEM_SIZE, 2: number of DM words dumped.
- DATA_WIDTH, 32: DM word width.
- RBITS, 5: register index width.
- BANK_SIZE, 2: number of registers dumped.
- REG_WIDTH, 32: register width.
- NBITS, 32: UART word, PC and counter width.
REQ-003 Ports SHALL be, one per line:
- clk in 1: clock.
- reset in 1: asynchronous active-low reset.
- rx_Data in NBITS: received UART word.
- rx_done in 1: one-cycle pulse, rx_Data valid.
- tx_done in 1: one-cycle pulse, previous word sent.
- halt_flag in 1: CPU reached halt.
- RB_Data in REG_WIDTH: register read data.
- DM_Data in DATA_WIDTH: DM read data.
- current_PC in NBITS: CPU PC.
- clock_count in NBITS: CPU cycle count.
- IM_Addr out IM_ADDR_LENGTH: IM write byte address.
- IM_Data out INST_WIDTH: IM write data.
- IM_We out 1: IM write enable.
- RB_Addr out RBITS: register read index.
- DM_Addr out DM_ADDR_LENGTH: DM read byte address.
- tx_Data out NBITS: word to transmit.
- tx_start out 1: one-cycle transmit request.
- clock_enable out 1: CPU clock enable.
- o_rst out 1: active-high CPU reset.

Function
REQ-004 The FSM SHALL have states RECVPROG, RECVMODE, RUNSTEP, RUNALL, SENDPC, SENDDM, SENDRB and SENDCLK, entering RECVPROG out of reset.
REQ-005 RECVPROG SHALL behave as follows:
- o_rst=1 and clock_enable=0.
- On each rx_done, register IM_Data=rx_Data and pulse IM_We for one cycle at IM_Addr.
- After the write, IM_Addr advances by 4 (address 0 after reset).
REQ-006 RECVPROG SHALL exit to RECVMODE after writing a word equal to 32'hFFFFFFFF (halt), or after IM_MEM_SIZE writes, whichever comes first.
REQ-007 RECVMODE SHALL behave as follows:
- o_rst=0, clock_enable=0.
- On rx_done, go to RUNSTEP if rx_Data==32'h10001000 (STEP code), otherwise go to RUNALL.
REQ-008 RUNSTEP SHALL drive clock_enable=1 for exactly one cycle and then go to SENDPC.
REQ-009 RUNALL SHALL hold clock_enable=1 until halt_flag is sampled high, then drop clock_enable and go to SENDPC; if halt_flag is already high on entry, it goes straight to SENDPC with zero enabled cycles.
REQ-010 Each send state SHALL use the same word handshake:
- Load tx_Data and pulse tx_start for one cycle.
- Wait for tx_done before the next word or the next state.
- tx_done arriving with no word outstanding is ignored.
REQ-011 The send sequence SHALL be:
- SENDPC: one word, current_PC.
- SENDDM: DM_MEM_SIZE words of DM_Data, DM_Addr = 0, 4, 8, ...
- SENDRB: BANK_SIZE words of RB_Data, RB_Addr = 0, 1, ...
- SENDCLK: one word, clock_count.
REQ-012 DM_Addr and RB_Addr SHALL be presented at least one cycle before tx_Data is latched.
REQ-013 After the SENDCLK tx_done, the FSM SHALL go to RECVPROG if halt_flag=1, otherwise to RECVMODE.
REQ-014 On every re-entry to RECVPROG, IM_Addr SHALL reset to 0 and o_rst SHALL rise.
REQ-015 rx_done in any state other than RECVPROG and RECVMODE SHALL be ignored.
REQ-016 Address counters SHALL wrap modulo their port width.

Reset
REQ-017 Asserting reset at any time SHALL immediately apply these values:
- State RECVPROG; all counters 0.
- IM_We=0, tx_start=0, clock_enable=0, o_rst=1.
- IM_Data, IM_Addr, DM_Addr, RB_Addr and tx_Data all 0.
- Any in-progress transfer is abandoned.

Structure
REQ-018 The state encoding, the STEP code 32'h10001000 and the HALT word 32'hFFFFFFFF SHALL live in a shared package, debug_pkg.
REQ-019 The block SHALL be a single module with no sub-modules; the transmit handshake may be coded as a local task or block.

Verification
REQ-020 Program load: rx words 0xFF, 0x0F, 0xFFFFFFFF -> IM_We pulses at IM_Addr 0, 4, 8 with those data, then state RECVMODE.
REQ-021 Step mode: rx 0x10001000 -> exactly one clock_enable cycle, then tx words in order 0x02 (PC), 0x7F, 0x7F (DM at addresses 0, 4), RB at index 0 and 1, 0x03 (clock_count); returns to RECVMODE.
REQ-022 Run all: rx 0x45003000, halt_flag raised after 4 cycles -> clock_enable high exactly until halt, same 6-word dump, then RECVPROG with o_rst=1.
REQ-023 Handshake: hold tx_done low for 3 cycles after tx_start -> tx_Data stable and no second tx_start until tx_done.
REQ-024 Overflow: 5 non-halt words with IM_MEM_SIZE=5 -> RECVMODE after the fifth write.
REQ-025 Reset mid-SENDDM -> all outputs at reset values immediately, RECVPROG after release.
